dcache_2way_top: RTL and testbench



---
 rtl/dcache_2way_top_if.sv | 29 ++
 rtl/dcache_2way_top.sv | 172 +++++++++++++++++
 tb/tb_dcache_2way_top.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_2way_top_if.sv
// Bundles the core-side (p1_*) and memory-side (mem_*) signals of the 2-way data cache.
// master is the cache itself; slave is the core/memory environment driving it.
interface dcache_2way_top_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [31:0]       p1_data_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic              p1_MemRead_i;
  logic              p1_MemWrite_i;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;

  modport master (
    input  mem_data_i, mem_ack_i, p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
    output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o, p1_data_o, p1_stall_o
  );

  modport slave (
    output mem_data_i, mem_ack_i, p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
    input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o, p1_data_o, p1_stall_o
  );
endinterface

// File: rtl/dcache_2way_top.sv
// Two-way set-associative, write-back, write-allocate data cache with per-set LRU.
// Misses latch their address and run MISS -> [WRITEBACK] -> REFILL -> REFILLOK -> IDLE.
module dcache_2way_top #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned SETS   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_2way_top_if.master   bus_io
);
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WSEL_W = OFF_W - 2;

  typedef enum logic [2:0] {StIdle, StMiss, StWriteback, StRefill, StRefillOk} state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0]  tag_q  [2][SETS];
  logic [LINE_W-1:0] data_q [2][SETS];
  logic [1:0]        valid_q [SETS];
  logic [1:0]        dirty_q [SETS];
  logic [SETS-1:0]   lru_q;

  logic [ADDR_W-1:0] miss_addr_q;
  logic              victim_q, victim_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              req, hit, hit_w, victim_dirty, refill_we;
  logic [1:0]        hit_way;
  logic [TAG_W-1:0]  p1_tag, miss_tag;
  logic [IDX_W-1:0]  p1_idx, miss_idx;
  logic [WSEL_W-1:0] p1_word;
  logic              unused_addr_bits;

  assign req      = bus_io.p1_MemRead_i | bus_io.p1_MemWrite_i;
  assign p1_tag   = bus_io.p1_addr_i[ADDR_W-1 -: TAG_W];
  assign p1_idx   = bus_io.p1_addr_i[OFF_W +: IDX_W];
  assign p1_word  = bus_io.p1_addr_i[2 +: WSEL_W];
  assign miss_tag = miss_addr_q[ADDR_W-1 -: TAG_W];
  assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{bus_io.p1_addr_i[1:0], miss_addr_q[OFF_W-1:0]};

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      hit_way[w] = valid_q[p1_idx][w] && (tag_q[w][p1_idx] == p1_tag);
    end
  end

  // Hits only count in IDLE so the freshly installed line is not seen during REFILLOK.
  assign hit   = req && (state_q == StIdle) && (|hit_way);
  assign hit_w = hit_way[1];

  assign bus_io.p1_stall_o = req & ~hit;
  assign bus_io.p1_data_o  = hit ? data_q[hit_w][p1_idx][{p1_word, 5'd0} +: 32] : 32'd0;

  always_comb begin
    if (!valid_q[miss_idx][0]) begin
      victim_d = 1'b0;
    end else if (!valid_q[miss_idx][1]) begin
      victim_d = 1'b1;
    end else begin
      victim_d = lru_q[miss_idx];
    end
  end

  assign victim_dirty = valid_q[miss_idx][victim_d] & dirty_q[miss_idx][victim_d];
  assign refill_we    = (state_q == StRefill) && bus_io.mem_ack_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (req && !hit) state_d = StMiss;
      StMiss:      state_d = victim_dirty ? StWriteback : StRefill;
      StWriteback: if (bus_io.mem_ack_i) state_d = StRefill;
      StRefill:    if (bus_io.mem_ack_i) state_d = StRefillOk;
      StRefillOk:  state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered memory request
  always_comb begin
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    unique case (state_q)
      StMiss: begin
        mem_enable_d = 1'b1;
        mem_write_d  = victim_dirty;
        mem_addr_d   = victim_dirty ? {tag_q[victim_d][miss_idx], miss_idx, {OFF_W{1'b0}}}
                                    : {miss_tag, miss_idx, {OFF_W{1'b0}}};
      end
      StWriteback: begin
        if (bus_io.mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = {miss_tag, miss_idx, {OFF_W{1'b0}}};
        end
      end
      StRefill: begin
        if (bus_io.mem_ack_i) begin
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      miss_addr_q  <= '0;
      victim_q     <= 1'b0;
    end else begin
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      if (state_q == StIdle && req && !hit) miss_addr_q <= bus_io.p1_addr_i;
      if (state_q == StMiss) victim_q <= victim_d;
    end
  end

  assign bus_io.mem_enable_o = mem_enable_q;
  assign bus_io.mem_write_o  = mem_write_q;
  assign bus_io.mem_addr_o   = mem_addr_q;
  assign bus_io.mem_data_o   = data_q[victim_q][miss_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      lru_q   <= '0;
    end else begin
      if (hit) begin
        lru_q[p1_idx] <= ~hit_w;
        if (bus_io.p1_MemWrite_i) dirty_q[p1_idx][hit_w] <= 1'b1;
      end
      if (refill_we) begin
        valid_q[miss_idx][victim_q] <= 1'b1;
        dirty_q[miss_idx][victim_q] <= 1'b0;
        lru_q[miss_idx]             <= ~victim_q;
      end
    end
  end

  // Tag and data contents need no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (refill_we) begin
      data_q[victim_q][miss_idx] <= bus_io.mem_data_i;
      tag_q[victim_q][miss_idx]  <= miss_tag;
    end else if (hit && bus_io.p1_MemWrite_i) begin
      data_q[hit_w][p1_idx][{p1_word, 5'd0} +: 32] <= bus_io.p1_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_2way_top.sv
// Directed bench for dcache_2way_top: a line memory model answers requests at the
// negative edge; each scenario task checks stall timing, data and memory traffic.
module tb_dcache_2way_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic        auto_ack = 1'b1;
  logic        force_ack = 1'b0;
  int          ack_delay = 1;
  int          cnt = 0;
  logic [31:0]  log_addr [$];
  logic         log_wr   [$];
  logic [255:0] log_data [$];
  logic [255:0] backing  [logic [31:0]];

  dcache_2way_top_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  dcache_2way_top #(.ADDR_W(32), .LINE_W(256), .SETS(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a ^ (k * 32'h1111_1111);
    return l;
  endfunction

  always @(negedge clk) begin
    bus.mem_ack_i = 1'b0;
    if (!rst && bus.mem_enable_o && auto_ack) begin
      cnt = cnt + 1;
      if (cnt == ack_delay) begin
        cnt = 0;
        bus.mem_ack_i = 1'b1;
        log_addr.push_back(bus.mem_addr_o);
        log_wr.push_back(bus.mem_write_o);
        log_data.push_back(bus.mem_data_o);
        if (bus.mem_write_o) backing[bus.mem_addr_o] = bus.mem_data_o;
        else bus.mem_data_i = backing.exists(bus.mem_addr_o) ? backing[bus.mem_addr_o]
                                                             : pattern(bus.mem_addr_o);
      end
    end else begin
      cnt = 0;
      if (force_ack) bus.mem_ack_i = 1'b1;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_wr.delete();
    log_data.delete();
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int cycles, output logic [31:0] rdata);
    @(negedge clk);
    bus.p1_addr_i = addr;
    bus.p1_data_i = wdata;
    bus.p1_MemRead_i = !wr;
    bus.p1_MemWrite_i = wr;
    cycles = 0;
    #1;
    while (bus.p1_stall_o === 1'b1 && cycles < 100) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    if (bus.p1_stall_o !== 1'b0) cycles = -1;
    rdata = bus.p1_data_o;
    @(negedge clk);
    bus.p1_MemRead_i = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.p1_addr_i = 32'h4;
    bus.p1_data_i = '0;
    bus.p1_MemRead_i = 1'b1;
    bus.p1_MemWrite_i = 1'b0;
    bus.mem_data_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (bus.mem_enable_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_enable: got %b expected 0", bus.mem_enable_o);
    end
    vectors++;
    if (bus.mem_write_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_write: got %b expected 0", bus.mem_write_o);
    end
    vectors++;
    if (bus.mem_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr_o);
    end
    vectors++;
    if (bus.p1_stall_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_stall: got %b expected 1", bus.p1_stall_o);
    end
    bus.p1_MemRead_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_miss();
    int cycles;
    clear_log();
    @(negedge clk);
    bus.p1_addr_i = 32'h4;
    bus.p1_MemRead_i = 1'b1;
    #1;
    vectors++;
    if (bus.p1_stall_o !== 1'b1) begin
      miscompares++; $display("FAIL miss_stall: got %b expected 1", bus.p1_stall_o);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL miss_request: got en=%b wr=%b addr=%h expected en=1 wr=0 addr=0",
               bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o);
    end
    cycles = 2;
    while (bus.p1_stall_o === 1'b1 && cycles < 100) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    vectors++;
    if (cycles !== 4) begin
      miscompares++; $display("FAIL miss_latency: got %0d cycles expected 4", cycles);
    end
    vectors++;
    if (bus.p1_data_o !== 32'h1111_1111) begin
      miscompares++; $display("FAIL miss_data: got %h expected 11111111", bus.p1_data_o);
    end
    @(negedge clk);
    bus.p1_MemRead_i = 1'b0;
    vectors++;
    if (log_addr.size() !== 1) begin
      miscompares++; $display("FAIL miss_traffic: got %0d transactions expected 1", log_addr.size());
    end
  endtask

  task automatic test_store_hit();
    int cycles;
    logic [31:0] rd;
    clear_log();
    access(1'b1, 32'h8, 32'hDEAD_BEEF, cycles, rd);
    vectors++;
    if (cycles !== 0) begin
      miscompares++; $display("FAIL store_hit_stall: got %0d cycles expected 0", cycles);
    end
    access(1'b0, 32'h8, 32'h0, cycles, rd);
    vectors++;
    if (rd !== 32'hDEAD_BEEF || cycles !== 0) begin
      miscompares++; $display("FAIL store_readback: got %h/%0d expected deadbeef/0", rd, cycles);
    end
    vectors++;
    if (log_addr.size() !== 0) begin
      miscompares++; $display("FAIL store_traffic: got %0d transactions expected 0", log_addr.size());
    end
  endtask

  task automatic test_two_ways();
    int cycles, c0, c1;
    logic [31:0] rd, rd0, rd1;
    clear_log();
    access(1'b0, 32'h400, 32'h0, cycles, rd);
    vectors++;
    if (cycles !== 4 || rd !== 32'h400) begin
      miscompares++; $display("FAIL way1_fill: got %0d/%h expected 4/00000400", cycles, rd);
    end
    vectors++;
    if (log_addr.size() !== 1 || log_addr[0] !== 32'h400 || log_wr[0] !== 1'b0) begin
      miscompares++; $display("FAIL way1_traffic: got n=%0d expected one refill at 400", log_addr.size());
    end
    clear_log();
    access(1'b0, 32'h8, 32'h0, c0, rd0);
    access(1'b0, 32'h404, 32'h0, c1, rd1);
    vectors++;
    if (c0 !== 0 || c1 !== 0 || rd0 !== 32'hDEAD_BEEF || rd1 !== 32'h1111_1511) begin
      miscompares++;
      $display("FAIL both_ways_hit: got %0d/%h %0d/%h expected 0/deadbeef 0/11111511",
               c0, rd0, c1, rd1);
    end
    vectors++;
    if (log_addr.size() !== 0) begin
      miscompares++; $display("FAIL both_ways_traffic: got %0d expected 0", log_addr.size());
    end
  endtask

  task automatic test_lru_clean();
    int cycles;
    logic [31:0] rd;
    access(1'b0, 32'h400, 32'h0, cycles, rd);
    access(1'b0, 32'h0, 32'h0, cycles, rd);
    clear_log();
    access(1'b0, 32'h800, 32'h0, cycles, rd);
    vectors++;
    if (cycles !== 4 || log_addr.size() !== 1 || log_addr[0] !== 32'h800 || log_wr[0] !== 1'b0) begin
      miscompares++; $display("FAIL lru_clean_evict: got %0d cycles n=%0d expected 4 cycles one refill at 800",
                              cycles, log_addr.size());
    end
    access(1'b0, 32'h8, 32'h0, cycles, rd);
    vectors++;
    if (cycles !== 0 || rd !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL lru_keep_mru: got %0d/%h expected 0/deadbeef", cycles, rd);
    end
    clear_log();
    access(1'b0, 32'h400, 32'h0, cycles, rd);
    vectors++;
    if (cycles !== 4 || log_addr.size() !== 1 || log_addr[0] !== 32'h400) begin
      miscompares++; $display("FAIL lru_evicted_misses: got %0d cycles n=%0d expected 4 / 1",
                              cycles, log_addr.size());
    end
  endtask

  task automatic test_dirty_evict();
    int cycles;
    logic [31:0] rd;
    access(1'b1, 32'h8, 32'hDEAD_BEEF, cycles, rd);
    access(1'b0, 32'h400, 32'h0, cycles, rd);
    clear_log();
    access(1'b0, 32'h800, 32'h0, cycles, rd);
    vectors++;
    if (cycles !== 5) begin
      miscompares++; $display("FAIL dirty_latency: got %0d cycles expected 5", cycles);
    end
    vectors++;
    if (log_addr.size() !== 2) begin
      miscompares++; $display("FAIL dirty_traffic: got %0d transactions expected 2", log_addr.size());
    end else begin
      vectors++;
      if (log_addr[0] !== 32'h0 || log_wr[0] !== 1'b1 || log_data[0][95:64] !== 32'hDEAD_BEEF) begin
        miscompares++; $display("FAIL dirty_writeback: got addr=%h wr=%b w2=%h expected 0/1/deadbeef",
                                log_addr[0], log_wr[0], log_data[0][95:64]);
      end
      vectors++;
      if (log_addr[1] !== 32'h800 || log_wr[1] !== 1'b0) begin
        miscompares++; $display("FAIL dirty_refill: got addr=%h wr=%b expected 800/0",
                                log_addr[1], log_wr[1]);
      end
    end
    access(1'b0, 32'h8, 32'h0, cycles, rd);
    vectors++;
    if (cycles !== 4 || rd !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL writeback_roundtrip: got %0d/%h expected 4/deadbeef", cycles, rd);
    end
  endtask

  task automatic test_write_miss();
    int cycles;
    logic [31:0] rd;
    access(1'b1, 32'h24, 32'hCAFE_F00D, cycles, rd);
    vectors++;
    if (cycles !== 4) begin
      miscompares++; $display("FAIL write_miss_latency: got %0d expected 4", cycles);
    end
    access(1'b0, 32'h24, 32'h0, cycles, rd);
    vectors++;
    if (cycles !== 0 || rd !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL write_miss_data: got %0d/%h expected 0/cafef00d", cycles, rd);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    logic [31:0] rd;
    access(1'b0, 32'h8, 32'h0, cycles, rd);
    auto_ack = 1'b0;
    @(negedge clk);
    bus.p1_addr_i = 32'h40;
    bus.p1_MemRead_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (bus.mem_enable_o !== 1'b1) begin
      miscompares++; $display("FAIL refill_pending: got %b expected 1", bus.mem_enable_o);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.mem_enable_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL async_reset: got en=%b addr=%h expected 0/0",
                              bus.mem_enable_o, bus.mem_addr_o);
    end
    bus.p1_MemRead_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.mem_enable_o !== 1'b0) begin
      miscompares++; $display("FAIL late_ack_ignored: got en=%b expected 0", bus.mem_enable_o);
    end
    auto_ack = 1'b1;
    clear_log();
    access(1'b0, 32'h8, 32'h0, cycles, rd);
    vectors++;
    if (cycles !== 4 || log_addr.size() !== 1 || rd !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL reset_invalidates: got %0d cycles n=%0d data=%h expected 4/1/deadbeef",
                              cycles, log_addr.size(), rd);
    end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store_hit();
    test_two_ways();
    test_lru_clean();
    test_dirty_evict();
    test_write_miss();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
